// File: rtl/traffic_light_ctrl.sv
// Traffic light controller: green/yellow/red sequencing with a seconds countdown,
// pedestrian shortening of green, and a night-time flashing-yellow mode.
module traffic_light_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 10000,
  parameter int unsigned GREEN_SEC     = 15,
  parameter int unsigned YELLOW_SEC    = 3,
  parameter int unsigned RED_SEC       = 10,
  parameter int unsigned PED_MIN_SEC   = 5
) (
  input  logic       clk_div_10000hz,
  input  logic       rst_n,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [1:0] state,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       ped_ack
);

  localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned REM_W  = 7;
  localparam int unsigned DIG_W  = 4;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);

  localparam logic [REM_W-1:0] GREEN_REM   = REM_W'(GREEN_SEC);
  localparam logic [REM_W-1:0] YELLOW_REM  = REM_W'(YELLOW_SEC);
  localparam logic [REM_W-1:0] RED_REM     = REM_W'(RED_SEC);
  localparam logic [REM_W-1:0] PED_MIN_REM = REM_W'(PED_MIN_SEC);

  localparam logic [DIG_W-1:0] RED_TENS = DIG_W'(RED_SEC / 10);
  localparam logic [DIG_W-1:0] RED_ONES = DIG_W'(RED_SEC % 10);

  // FSM states
  localparam logic [1:0] S_GREEN  = 2'd0;
  localparam logic [1:0] S_YELLOW = 2'd1;
  localparam logic [1:0] S_RED    = 2'd2;
  localparam logic [1:0] S_FLASH  = 2'd3;

  // Light codes shown on the display
  localparam logic [1:0] L_RED    = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_GREEN  = 2'b10;
  localparam logic [1:0] L_NONE   = 2'b11;

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [1:0]        fsm_q, fsm_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [1:0]        light_q, light_d;
  logic [DIG_W-1:0]  tens_q, tens_d;
  logic [DIG_W-1:0]  ones_q, ones_d;
  logic              ack_q, ack_d;
  logic              ped_prev_q, ped_prev_d;

  logic sec_pulse_c;
  logic ped_edge_c;

  assign sec_pulse_c = (tick_q == TICK_LAST);
  assign ped_edge_c  = ped_req & ~ped_prev_q;

  // State, counters and registered outputs
  always_ff @(posedge clk_div_10000hz or negedge rst_n) begin
    if (!rst_n) begin
      tick_q     <= '0;
      fsm_q      <= S_RED;
      rem_q      <= RED_REM;
      light_q    <= L_RED;
      tens_q     <= RED_TENS;
      ones_q     <= RED_ONES;
      ack_q      <= 1'b0;
      ped_prev_q <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      fsm_q      <= fsm_d;
      rem_q      <= rem_d;
      light_q    <= light_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      ack_q      <= ack_d;
      ped_prev_q <= ped_prev_d;
    end
  end

  // Next-state: night mode first, then phase expiry, then countdown and pedestrian shortening
  always_comb begin
    fsm_d      = fsm_q;
    rem_d      = rem_q;
    light_d    = light_q;
    ack_d      = 1'b0;
    ped_prev_d = ped_req;
    tick_d     = sec_pulse_c ? '0 : tick_q + TICK_W'(1);

    case (fsm_q)
      S_FLASH: begin
        if (!night_mode) begin
          fsm_d   = S_RED;
          rem_d   = RED_REM;
          light_d = L_RED;
          tick_d  = '0;
        end else if (sec_pulse_c) begin
          light_d = (light_q == L_YELLOW) ? L_NONE : L_YELLOW;
        end
      end
      default: begin
        if (night_mode) begin
          fsm_d   = S_FLASH;
          rem_d   = '0;
          light_d = L_YELLOW;
          tick_d  = '0;
        end else if (sec_pulse_c && (rem_q == REM_W'(1))) begin
          // Expiry wins over a coincident pedestrian edge
          case (fsm_q)
            S_GREEN: begin
              fsm_d   = S_YELLOW;
              rem_d   = YELLOW_REM;
              light_d = L_YELLOW;
            end
            S_YELLOW: begin
              fsm_d   = S_RED;
              rem_d   = RED_REM;
              light_d = L_RED;
            end
            default: begin
              fsm_d   = S_GREEN;
              rem_d   = GREEN_REM;
              light_d = L_GREEN;
            end
          endcase
        end else begin
          if (sec_pulse_c) begin
            rem_d = rem_q - REM_W'(1);
          end
          if ((fsm_q == S_GREEN) && ped_edge_c) begin
            ack_d = 1'b1;
            if (rem_q > PED_MIN_REM) begin
              rem_d = PED_MIN_REM;
            end
          end
        end
      end
    endcase

    tens_d = DIG_W'(rem_d / REM_W'(10));
    ones_d = DIG_W'(rem_d % REM_W'(10));
  end

  assign state    = light_q;
  assign sec_tens = tens_q;
  assign sec_ones = ones_q;
  assign ped_ack  = ack_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed testbench for traffic_light_ctrl with a short timebase
// (4 ticks/s, green 6 s, yellow 2 s, red 3 s, pedestrian minimum 2 s).
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ped_req;
  logic       night_mode;
  logic [1:0] state;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       ped_ack;

  int errors = 0;
  int checks = 0;

  traffic_light_ctrl #(
    .TICKS_PER_SEC(4),
    .GREEN_SEC    (6),
    .YELLOW_SEC   (2),
    .RED_SEC      (3),
    .PED_MIN_SEC  (2)
  ) dut (
    .clk_div_10000hz(clk),
    .rst_n          (rst_n),
    .ped_req        (ped_req),
    .night_mode     (night_mode),
    .state          (state),
    .sec_tens       (sec_tens),
    .sec_ones       (sec_ones),
    .ped_ack        (ped_ack)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset and release between edges; the release point is observation index 0
  task automatic do_reset();
    rst_n      = 1'b0;
    ped_req    = 1'b0;
    night_mode = 1'b0;
    adv(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    ped_req    = 1'b0;
    night_mode = 1'b0;
    adv(3);
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: got %b want 00", state);
    end
    checks++;
    if ({sec_tens, sec_ones} !== 8'h03) begin
      errors++;
      $display("FAIL reset_digits: got %0d%0d want 03", sec_tens, sec_ones);
    end
    checks++;
    if (ped_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack: got %b want 0", ped_ack);
    end
  endtask

  // Full cycle: 12 red, 24 green, 8 yellow, then red again
  task automatic test_free_run();
    logic [1:0] exp_state;
    int         exp_rem;
    do_reset();
    for (int i = 0; i <= 44; i++) begin
      if (i < 12) begin
        exp_state = 2'b00; exp_rem = 3 - i / 4;
      end else if (i < 36) begin
        exp_state = 2'b10; exp_rem = 6 - (i - 12) / 4;
      end else if (i < 44) begin
        exp_state = 2'b01; exp_rem = 2 - (i - 36) / 4;
      end else begin
        exp_state = 2'b00; exp_rem = 3;
      end
      checks++;
      if (state !== exp_state || sec_tens !== 4'(exp_rem / 10) || sec_ones !== 4'(exp_rem % 10)) begin
        errors++;
        $display("FAIL free_run[%0d]: got state=%b digits=%0d%0d want state=%b rem=%0d",
                 i, state, sec_tens, sec_ones, exp_state, exp_rem);
      end
      checks++;
      if (ped_ack !== 1'b0) begin
        errors++;
        $display("FAIL free_run_ack[%0d]: got %b want 0", i, ped_ack);
      end
      if (i < 44) adv(1);
    end
  endtask

  // Request with rem=5 shortens green to 2 s; yellow 8 edges after the request
  task automatic test_ped_shorten();
    do_reset();
    adv(16);
    ped_req = 1'b1;
    adv(1);
    checks++;
    if (ped_ack !== 1'b1) begin
      errors++;
      $display("FAIL ped_shorten_ack: got %b want 1", ped_ack);
    end
    checks++;
    if ({sec_tens, sec_ones} !== 8'h02 || state !== 2'b10) begin
      errors++;
      $display("FAIL ped_shorten_rem: got state=%b digits=%0d%0d want 10 02", state, sec_tens, sec_ones);
    end
    ped_req = 1'b0;
    adv(1);
    checks++;
    if (ped_ack !== 1'b0) begin
      errors++;
      $display("FAIL ped_shorten_ack_pulse: got %b want 0", ped_ack);
    end
    adv(5);
    checks++;
    if (state !== 2'b10 || sec_ones !== 4'd1) begin
      errors++;
      $display("FAIL ped_shorten_pre: got state=%b ones=%0d want 10 1", state, sec_ones);
    end
    adv(1);
    checks++;
    if (state !== 2'b01 || {sec_tens, sec_ones} !== 8'h02) begin
      errors++;
      $display("FAIL ped_shorten_yellow: got state=%b digits=%0d%0d want 01 02", state, sec_tens, sec_ones);
    end
  endtask

  // Request at rem=2 acks without change; request in red is ignored
  task automatic test_ped_no_change();
    do_reset();
    adv(28);
    ped_req = 1'b1;
    adv(1);
    checks++;
    if (ped_ack !== 1'b1 || sec_ones !== 4'd2 || state !== 2'b10) begin
      errors++;
      $display("FAIL ped_min_green: got ack=%b state=%b ones=%0d want 1 10 2", ped_ack, state, sec_ones);
    end
    ped_req = 1'b0;
    adv(3);
    checks++;
    if (state !== 2'b10 || sec_ones !== 4'd1) begin
      errors++;
      $display("FAIL ped_min_keep: got state=%b ones=%0d want 10 1", state, sec_ones);
    end
    adv(13);
    ped_req = 1'b1;
    adv(1);
    checks++;
    if (ped_ack !== 1'b0 || state !== 2'b00 || {sec_tens, sec_ones} !== 8'h03) begin
      errors++;
      $display("FAIL ped_in_red: got ack=%b state=%b digits=%0d%0d want 0 00 03", ped_ack, state, sec_tens, sec_ones);
    end
    adv(1);
    checks++;
    if (ped_ack !== 1'b0) begin
      errors++;
      $display("FAIL ped_in_red_late: got ack=%b want 0", ped_ack);
    end
    adv(1);
    checks++;
    if (sec_ones !== 4'd2 || state !== 2'b00) begin
      errors++;
      $display("FAIL ped_in_red_count: got state=%b ones=%0d want 00 2", state, sec_ones);
    end
    ped_req = 1'b0;
  endtask

  // Request coinciding with green expiry: expiry wins, no ack
  task automatic test_ped_at_expiry();
    do_reset();
    adv(35);
    ped_req = 1'b1;
    adv(1);
    checks++;
    if (state !== 2'b01 || ped_ack !== 1'b0 || {sec_tens, sec_ones} !== 8'h02) begin
      errors++;
      $display("FAIL ped_expiry: got state=%b ack=%b digits=%0d%0d want 01 0 02", state, ped_ack, sec_tens, sec_ones);
    end
    ped_req = 1'b0;
  endtask

  // Night mode mid-green, flashing, then return to a full red
  task automatic test_night();
    do_reset();
    adv(18);
    night_mode = 1'b1;
    adv(1);
    checks++;
    if (state !== 2'b01 || {sec_tens, sec_ones} !== 8'h00) begin
      errors++;
      $display("FAIL night_entry: got state=%b digits=%0d%0d want 01 00", state, sec_tens, sec_ones);
    end
    adv(3);
    checks++;
    if (state !== 2'b01) begin
      errors++;
      $display("FAIL night_hold_y: got %b want 01", state);
    end
    adv(1);
    checks++;
    if (state !== 2'b11 || {sec_tens, sec_ones} !== 8'h00) begin
      errors++;
      $display("FAIL night_none: got state=%b digits=%0d%0d want 11 00", state, sec_tens, sec_ones);
    end
    adv(3);
    checks++;
    if (state !== 2'b11) begin
      errors++;
      $display("FAIL night_hold_n: got %b want 11", state);
    end
    adv(1);
    checks++;
    if (state !== 2'b01) begin
      errors++;
      $display("FAIL night_back_y: got %b want 01", state);
    end
    adv(1);
    night_mode = 1'b0;
    adv(1);
    checks++;
    if (state !== 2'b00 || {sec_tens, sec_ones} !== 8'h03) begin
      errors++;
      $display("FAIL night_exit: got state=%b digits=%0d%0d want 00 03", state, sec_tens, sec_ones);
    end
    adv(11);
    checks++;
    if (state !== 2'b00 || sec_ones !== 4'd1) begin
      errors++;
      $display("FAIL night_red_end: got state=%b ones=%0d want 00 1", state, sec_ones);
    end
    adv(1);
    checks++;
    if (state !== 2'b10 || sec_ones !== 4'd6) begin
      errors++;
      $display("FAIL night_to_green: got state=%b ones=%0d want 10 6", state, sec_ones);
    end
  endtask

  // Asynchronous reset mid-yellow, then a full red after release
  task automatic test_reset_mid();
    do_reset();
    adv(38);
    checks++;
    if (state !== 2'b01) begin
      errors++;
      $display("FAIL mid_pre_yellow: got %b want 01", state);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 2'b00 || {sec_tens, sec_ones} !== 8'h03 || ped_ack !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_reset: got state=%b digits=%0d%0d ack=%b want 00 03 0", state, sec_tens, sec_ones, ped_ack);
    end
    adv(2);
    rst_n = 1'b1;
    adv(11);
    checks++;
    if (state !== 2'b00 || sec_ones !== 4'd1) begin
      errors++;
      $display("FAIL mid_red_end: got state=%b ones=%0d want 00 1", state, sec_ones);
    end
    adv(1);
    checks++;
    if (state !== 2'b10 || sec_ones !== 4'd6) begin
      errors++;
      $display("FAIL mid_to_green: got state=%b ones=%0d want 10 6", state, sec_ones);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_ped_shorten();
    test_ped_no_change();
    test_ped_at_expiry();
    test_night();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
